// File: rtl/guvm_wb_arbiter.sv
// Two-master Wishbone arbiter: round-robin grant per bus cycle, locked while the
// owner holds cyc, with a stalled-strobe timeout that answers the owner with err.
//
// state | meaning
// IDLE  | no master owns the slave port
// GNT0  | master 0 (core) owns the slave port
// GNT1  | master 1 (bench loader) owns the slave port
module guvm_wb_arbiter #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_m0_cyc,
    input  logic         i_m0_stb,
    input  logic         i_m0_we,
    input  logic [31:0]  i_m0_adr,
    input  logic [15:0]  i_m0_sel,
    input  logic [127:0] i_m0_dat,
    output logic [127:0] o_m0_dat,
    output logic         o_m0_ack,
    output logic         o_m0_err,
    input  logic         i_m1_cyc,
    input  logic         i_m1_stb,
    input  logic         i_m1_we,
    input  logic [31:0]  i_m1_adr,
    input  logic [15:0]  i_m1_sel,
    input  logic [127:0] i_m1_dat,
    output logic [127:0] o_m1_dat,
    output logic         o_m1_ack,
    output logic         o_m1_err,
    output logic         o_s_cyc,
    output logic         o_s_stb,
    output logic         o_s_we,
    output logic [31:0]  o_s_adr,
    output logic [15:0]  o_s_sel,
    output logic [127:0] o_s_dat,
    input  logic [127:0] i_s_dat,
    input  logic         i_s_ack,
    input  logic         i_s_err,
    output logic [1:0]   o_gnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic [9:0] CNT_LAST = 10'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic [9:0]  cnt_q, cnt_d;
    logic        to_err_q, to_err_d;
    logic [1:0]  gnt_q, gnt_d;

    // Slave request mux; the strobe is withheld during the timeout-error cycle.
    always_comb begin
        o_s_cyc = 1'b0;
        o_s_stb = 1'b0;
        o_s_we  = 1'b0;
        o_s_adr = '0;
        o_s_sel = '0;
        o_s_dat = '0;
        case (state_q)
            GNT0: begin
                o_s_cyc = i_m0_cyc;
                o_s_stb = i_m0_stb & ~to_err_q;
                o_s_we  = i_m0_we;
                o_s_adr = i_m0_adr;
                o_s_sel = i_m0_sel;
                o_s_dat = i_m0_dat;
            end
            GNT1: begin
                o_s_cyc = i_m1_cyc;
                o_s_stb = i_m1_stb & ~to_err_q;
                o_s_we  = i_m1_we;
                o_s_adr = i_m1_adr;
                o_s_sel = i_m1_sel;
                o_s_dat = i_m1_dat;
            end
            default: ;
        endcase
    end

    assign o_m0_ack = (state_q == GNT0) & i_s_ack;
    assign o_m0_err = (state_q == GNT0) & (i_s_err | to_err_q);
    assign o_m0_dat = (state_q == GNT0) ? i_s_dat : '0;
    assign o_m1_ack = (state_q == GNT1) & i_s_ack;
    assign o_m1_err = (state_q == GNT1) & (i_s_err | to_err_q);
    assign o_m1_dat = (state_q == GNT1) ? i_s_dat : '0;
    assign o_gnt    = gnt_q;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (i_m0_cyc && i_m1_cyc) state_d = last_q ? GNT0 : GNT1;
                else if (i_m0_cyc)        state_d = GNT0;
                else if (i_m1_cyc)        state_d = GNT1;
            end
            GNT0: begin
                if (!i_m0_cyc) begin
                    last_d  = 1'b0;
                    state_d = i_m1_cyc ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (!i_m1_cyc) begin
                    last_d  = 1'b1;
                    state_d = i_m0_cyc ? GNT0 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A slave response in the last counted cycle clears the count, so ack wins over timeout.
    always_comb begin
        cnt_d    = cnt_q;
        to_err_d = 1'b0;
        if (state_q == IDLE || state_d != state_q || i_s_ack || i_s_err) begin
            cnt_d = '0;
        end else if (o_s_stb) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d    = '0;
                to_err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 10'd1;
            end
        end
    end

    always_comb begin
        case (state_d)
            GNT0:    gnt_d = 2'b01;
            GNT1:    gnt_d = 2'b10;
            default: gnt_d = 2'b00;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            cnt_q    <= '0;
            to_err_q <= 1'b0;
            gnt_q    <= 2'b00;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            to_err_q <= to_err_d;
            gnt_q    <= gnt_d;
        end
    end

endmodule
